// File: rtl/dds_pkg.sv
// Shared constants, FSM state type and button helpers for the DDS parameter controller.
// Optional auto-repeat is enabled by defining DDS_AUTO_REPEAT_EN.
package dds_pkg;

  localparam logic [31:0] FREQ_STEP_FINE   = 32'd43;
  localparam logic [31:0] FREQ_STEP_MID    = 32'd42950;
  localparam logic [31:0] FREQ_STEP_COARSE = 32'd42949673;
  // Upper tuning-word limit keeps the DDS output below Nyquist.
  localparam logic [31:0] FREQ_MAX         = 32'h7FFF_FFFF;
  localparam logic [31:0] DUTY_STEP        = 32'd429496729;
  localparam logic [31:0] DUTY_MAX         = 32'hFFFF_FFFF;
  localparam logic [31:0] DUTY_INIT        = 32'h8000_0000;
  localparam logic [31:0] PHASE_STEP       = 32'h0800_0000;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2,
    ST_RELEASE  = 2'd3
  } dbState_e;

  function automatic logic oneLow(input logic [2:0] pb);
    return pb inside {3'b110, 3'b101, 3'b011};
  endfunction

  function automatic logic [1:0] btnIndex(input logic [2:0] pb);
    case (pb)
      3'b110:  return 2'd0;
      3'b101:  return 2'd1;
      default: return 2'd2;
    endcase
  endfunction

  function automatic logic [31:0] freqStep(input logic [1:0] idx);
    case (idx)
      2'd0:    return FREQ_STEP_FINE;
      2'd1:    return FREQ_STEP_MID;
      default: return FREQ_STEP_COARSE;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Input synchronizers and single-button debounce FSM; emits one step pulse per accepted
// press (plus periodic repeats while held when DDS_AUTO_REPEAT_EN is defined).
module btn_debounce
  import dds_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       modeAsync,
  input  logic       dirAsync,
  input  logic [2:0] btnAsync,
  output logic       modeSync,
  output logic       dirSync,
  output logic       stepPulse,
  output logic [1:0] btnIdx
);

  localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [4:0]       sync_p0;
  logic [4:0]       sync_p1;
  logic [2:0]       pb;
  logic [2:0]       pattern;
  logic [DEB_W-1:0] cnt;
  logic             rptFire;
  dbState_e         state;

  // Stage p0/p1: two-flop synchronizer, idles with all buttons released.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= 5'b00111;
      sync_p1 <= 5'b00111;
    end else begin
      sync_p0 <= {modeAsync, dirAsync, btnAsync};
      sync_p1 <= sync_p0;
    end
  end

  assign modeSync = sync_p1[4];
  assign dirSync  = sync_p1[3];
  assign pb       = sync_p1[2:0];

`ifdef DDS_AUTO_REPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_CYCLES + 1);
  logic [RPT_W-1:0] rptCnt;
  logic             holding;

  assign holding = (state == ST_PRESSED) && (pb == pattern);
  assign rptFire = holding && (rptCnt >= RPT_W'(REPEAT_CYCLES - 1));

  // Zero on the cycle PRESSED is entered, so repeats land every REPEAT_CYCLES from entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rptCnt <= '0;
    end else if (!holding || rptFire) begin
      rptCnt <= '0;
    end else begin
      rptCnt <= rptCnt + 1'b1;
    end
  end
`else
  logic unusedRepeat;
  assign unusedRepeat = (REPEAT_CYCLES > 0);
  assign rptFire      = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      pattern   <= 3'b111;
      cnt       <= '0;
      stepPulse <= 1'b0;
      btnIdx    <= 2'd0;
    end else begin
      stepPulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt <= DEB_W'(1);
          if (oneLow(pb)) begin
            state   <= ST_DEBOUNCE;
            pattern <= pb;
          end
        end
        ST_DEBOUNCE: begin
          if (pb != pattern) begin
            state <= ST_IDLE;
            cnt   <= DEB_W'(1);
          end else if (cnt >= DEB_W'(DEBOUNCE_CYCLES - 1)) begin
            state     <= ST_PRESSED;
            stepPulse <= 1'b1;
            btnIdx    <= btnIndex(pattern);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_PRESSED: begin
          cnt <= DEB_W'(1);
          if (pb == 3'b111) begin
            state <= ST_RELEASE;
          end else if (rptFire) begin
            stepPulse <= 1'b1;
          end
        end
        ST_RELEASE: begin
          if (pb != 3'b111) begin
            cnt <= '0;
          end else if (cnt >= DEB_W'(DEBOUNCE_CYCLES - 1)) begin
            state <= ST_IDLE;
            cnt   <= DEB_W'(1);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/dds_param_ctrl.sv
// Push-button controlled DDS frequency/phase/PWM parameter registers with saturation.
// Define DDS_AUTO_REPEAT_EN to enable auto-repeat of a held button.
module dds_param_ctrl
  import dds_pkg::*;
#(
  parameter int          DEBOUNCE_CYCLES = 500000,
  parameter int          REPEAT_CYCLES   = 25000000,
  parameter logic [31:0] FREQ_INIT       = 32'd42949673
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        FreqPhaseSelect,
  input  logic        UpDownSelect,
  input  logic [2:0]  PushButton,
  output logic [31:0] FreqWord,
  output logic [31:0] PhaseWord,
  output logic [31:0] PWMDuty,
  output logic        update_stb
);

  logic        modeSync;
  logic        dirSync;
  logic        stepPulse;
  logic [1:0]  btnIdx;
  logic [31:0] freqNext;
  logic [31:0] phaseNext;
  logic [31:0] dutyNext;

  function automatic logic [31:0] satInc(input logic [31:0] val, input logic [31:0] step,
                                         input logic [31:0] lim);
    logic [32:0] sum;
    sum = {1'b0, val} + {1'b0, step};
    return (sum > {1'b0, lim}) ? lim : sum[31:0];
  endfunction

  function automatic logic [31:0] satDec(input logic [31:0] val, input logic [31:0] step);
    return (val < step) ? 32'd0 : val - step;
  endfunction

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_CYCLES  (REPEAT_CYCLES)
  ) uDebounce (
    .clk      (clk),
    .reset    (reset),
    .modeAsync(FreqPhaseSelect),
    .dirAsync (UpDownSelect),
    .btnAsync (PushButton),
    .modeSync (modeSync),
    .dirSync  (dirSync),
    .stepPulse(stepPulse),
    .btnIdx   (btnIdx)
  );

  // Mode and direction are taken from the same cycle as the step pulse; later changes
  // only matter for the next pulse.
  always_comb begin
    freqNext  = FreqWord;
    phaseNext = PhaseWord;
    dutyNext  = PWMDuty;
    if (stepPulse) begin
      if (modeSync) begin
        freqNext = dirSync ? satInc(FreqWord, freqStep(btnIdx), FREQ_MAX)
                           : satDec(FreqWord, freqStep(btnIdx));
      end else if (btnIdx == 2'd0) begin
        dutyNext = dirSync ? satInc(PWMDuty, DUTY_STEP, DUTY_MAX)
                           : satDec(PWMDuty, DUTY_STEP);
      end else if (btnIdx == 2'd1) begin
        phaseNext = dirSync ? PhaseWord + PHASE_STEP : PhaseWord - PHASE_STEP;
      end
    end
  end

  // Output stage: strobe only when a stored word really moves.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      FreqWord   <= FREQ_INIT;
      PhaseWord  <= 32'd0;
      PWMDuty    <= DUTY_INIT;
      update_stb <= 1'b0;
    end else begin
      FreqWord   <= freqNext;
      PhaseWord  <= phaseNext;
      PWMDuty    <= dutyNext;
      update_stb <= (freqNext != FreqWord) || (phaseNext != PhaseWord) || (dutyNext != PWMDuty);
    end
  end

endmodule

// File: tb/tb_dds_param_ctrl.sv
// Randomized bench for dds_param_ctrl against an arithmetic reference model.
// Repeat-count expectations follow DDS_AUTO_REPEAT_EN.
module tb_dds_param_ctrl;
  import dds_pkg::FREQ_MAX;

  localparam int          DEB    = 4;
  localparam int          RPT    = 16;
  localparam logic [31:0] F_INIT = 32'd42949673;
  localparam longint      TWO32  = 64'h1_0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        fps;
  logic        uds;
  logic [2:0]  pb;
  logic [31:0] fw;
  logic [31:0] pw;
  logic [31:0] duty;
  logic        stb;

  int     nVec = 0;
  int     nErr = 0;
  int     stbSeen = 0;
  int     stbExp = 0;
  longint mFreq;
  longint mPhase;
  longint mDuty;

  dds_param_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_CYCLES  (RPT),
    .FREQ_INIT      (F_INIT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .FreqPhaseSelect(fps),
    .UpDownSelect   (uds),
    .PushButton     (pb),
    .FreqWord       (fw),
    .PhaseWord      (pw),
    .PWMDuty        (duty),
    .update_stb     (stb)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (!reset && stb) stbSeen++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVec++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic void modelReset();
    mFreq  = longint'(F_INIT);
    mPhase = 0;
    mDuty  = 64'h8000_0000;
  endfunction

  // One accepted step: plain arithmetic with clamping or modular wrap.
  function automatic void modelStep(input int idx, input bit mode, input bit dir);
    longint oldF, oldP, oldD, s;
    longint stepF[3];
    stepF = '{43, 42950, 42949673};
    oldF = mFreq; oldP = mPhase; oldD = mDuty;
    if (mode) begin
      s = dir ? stepF[idx] : -stepF[idx];
      mFreq = mFreq + s;
      if (mFreq > longint'(FREQ_MAX)) mFreq = longint'(FREQ_MAX);
      if (mFreq < 0) mFreq = 0;
    end else if (idx == 0) begin
      s = dir ? 429496729 : -429496729;
      mDuty = mDuty + s;
      if (mDuty > TWO32 - 1) mDuty = TWO32 - 1;
      if (mDuty < 0) mDuty = 0;
    end else if (idx == 1) begin
      s = dir ? 134217728 : -134217728;
      mPhase = mPhase + s;
      if (mPhase < 0) mPhase = mPhase + TWO32;
      if (mPhase >= TWO32) mPhase = mPhase - TWO32;
    end
    if (mFreq != oldF || mPhase != oldP || mDuty != oldD) stbExp++;
  endfunction

  task automatic checkAll(input string tag);
    chk({tag, ".freq"}, fw, mFreq[31:0]);
    chk({tag, ".phase"}, pw, mPhase[31:0]);
    chk({tag, ".duty"}, duty, mDuty[31:0]);
    chk({tag, ".stbCount"}, 32'(stbSeen), 32'(stbExp));
  endtask

  // Sets mode/direction, holds a button pattern, optionally flips mode/direction late in the hold.
  task automatic doPress(input logic [2:0] pat, input int hold, input bit mode, input bit dir,
                         input bit twiddle);
    @(negedge clk);
    fps = mode;
    uds = dir;
    repeat (4) @(negedge clk);
    pb = pat;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (twiddle && i == hold - 3) begin
        fps = ~mode;
        uds = ~dir;
      end
    end
    pb = 3'b111;
    repeat (10) @(negedge clk);
  endtask

  function automatic int patIdx(input logic [2:0] pat);
    if (pat == 3'b110) return 0;
    if (pat == 3'b101) return 1;
    return 2;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] onePats[3];
    logic [2:0] multiPats[5];
    logic [2:0] pat;
    int hold;
    bit mode, dir, tw;
    onePats   = '{3'b110, 3'b101, 3'b011};
    multiPats = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b111};

    reset = 1'b1; pb = 3'b111; fps = 1'b0; uds = 1'b0;
    modelReset();
    #3;
    chk("reset.freq", fw, F_INIT);
    chk("reset.phase", pw, 32'h0);
    chk("reset.duty", duty, 32'h8000_0000);
    chk("reset.stb", {31'b0, stb}, 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 32; i++) begin
      doPress(3'b101, 10, 1'b0, 1'b1, 1'b0);
      modelStep(1, 1'b0, 1'b1);
    end
    chk("phaseWrap.zero", pw, 32'h0);
    checkAll("phaseWrap");

    doPress(3'b011, 10, 1'b1, 1'b1, 1'b0);
    modelStep(2, 1'b1, 1'b1);
    chk("coarseUp.value", fw, F_INIT + 32'd42949673);
    checkAll("coarseUp");

    doPress(3'b110, 3, 1'b1, 1'b1, 1'b0);
    checkAll("glitch");
    doPress(3'b110, 10, 1'b1, 1'b1, 1'b0);
    modelStep(0, 1'b1, 1'b1);
    checkAll("afterGlitch");

    for (int i = 0; i < 7; i++) begin
      doPress(3'b110, 10, 1'b0, 1'b0, 1'b0);
      modelStep(0, 1'b0, 1'b0);
    end
    chk("dutyFloor.value", duty, 32'h0);
    checkAll("dutyFloor");

    for (int i = 0; i < 12; i++) begin
      doPress(3'b110, 10, 1'b0, 1'b1, 1'b0);
      modelStep(0, 1'b0, 1'b1);
    end
    chk("dutyCeil.value", duty, 32'hFFFF_FFFF);
    checkAll("dutyCeil");

    for (int i = 0; i < 4; i++) begin
      doPress(3'b011, 10, 1'b1, 1'b0, 1'b0);
      modelStep(2, 1'b1, 1'b0);
    end
    chk("freqFloor.value", fw, 32'h0);
    checkAll("freqFloor");

    for (int i = 0; i < 52; i++) begin
      doPress(3'b011, 10, 1'b1, 1'b1, 1'b0);
      modelStep(2, 1'b1, 1'b1);
    end
    chk("freqCeil.value", fw, FREQ_MAX);
    checkAll("freqCeil");

    doPress(3'b100, 12, 1'b1, 1'b0, 1'b0);
    doPress(3'b000, 12, 1'b0, 1'b1, 1'b0);
    checkAll("multiButton");

    @(negedge clk);
    fps = 1'b1; uds = 1'b0;
    repeat (4) @(negedge clk);
    pb = 3'b101;
    repeat (12) @(negedge clk);
    modelStep(1, 1'b1, 1'b0);
    checkAll("preReset");
    #2 reset = 1'b1;
    #1;
    modelReset();
    chk("asyncReset.freq", fw, F_INIT);
    chk("asyncReset.phase", pw, 32'h0);
    chk("asyncReset.duty", duty, 32'h8000_0000);
    @(negedge clk);
    pb = 3'b111;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    checkAll("postReset");
    doPress(3'b101, 10, 1'b1, 1'b0, 1'b0);
    modelStep(1, 1'b1, 1'b0);
    checkAll("rePress");

    doPress(3'b110, 56, 1'b1, 1'b1, 1'b0);
`ifdef DDS_AUTO_REPEAT_EN
    for (int i = 0; i < 4; i++) modelStep(0, 1'b1, 1'b1);
`else
    modelStep(0, 1'b1, 1'b1);
`endif
    checkAll("longHold");

    for (int v = 0; v < 40; v++) begin
      if ($urandom_range(0, 9) < 7) pat = onePats[$urandom_range(0, 2)];
      else pat = multiPats[$urandom_range(0, 4)];
      hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(10, 18));
      mode = 1'($urandom_range(0, 1));
      dir  = 1'($urandom_range(0, 1));
      tw   = 1'($urandom_range(0, 1));
      doPress(pat, hold, mode, dir, tw);
      if ((pat == 3'b110 || pat == 3'b101 || pat == 3'b011) && hold >= 10)
        modelStep(patIdx(pat), mode, dir);
      checkAll($sformatf("rand%0d", v));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
